uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 15 +
 rtl/uart_rx.sv | 90 +++++++++
 tb/tb_uart_rx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity encodings, FSM state constants and baud divisor helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer for the rx line plus falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {rx, s1, s2};
  assign rx_s = s2;
  assign fall = s3 & ~s2;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with ready/acknowledge handshake
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_LEN   = 8,
  parameter int PARITY_BIT = 0,
  parameter int STOP_BIT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic                data_readed,
  output logic [DATA_LEN-1:0] out_data,
  output logic                data_ready,
  output logic                overwritten,
  output logic                parity_error
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [3:0] LAST_D = 4'(DATA_LEN - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BIT - 1);
  logic rx_s, fall, tick, par_exp, perr, done;
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] bit_cnt;
  logic [DATA_LEN-1:0] sh;
  uart_rx_sync u_sync (.clk(clk), .rst(rst), .rx(rx), .rx_s(rx_s), .fall(fall));
  always_comb begin
    tick = cnt == ((state == ST_START) ? HALF : FULL);
    par_exp = (PARITY_BIT == PAR_EVEN) ? ^sh : ~^sh;
  end
  // START samples at half a bit, every later state at full-bit intervals (mid-bit)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      perr    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= (state == ST_IDLE || tick) ? '0 : cnt + 1'b1;
      case (state)
        ST_IDLE: if (fall) begin
          state   <= ST_START;
          bit_cnt <= '0;
          perr    <= 1'b0;
        end
        ST_START: if (tick) state <= rx_s ? ST_IDLE : ST_DATA;
        ST_DATA: if (tick) begin
          sh      <= {rx_s, sh[DATA_LEN-1:1]};
          bit_cnt <= (bit_cnt == LAST_D) ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == LAST_D) state <= (PARITY_BIT == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
        ST_PARITY: if (tick) begin
          perr  <= rx_s != par_exp;
          state <= ST_STOP;
        end
        ST_STOP: if (tick) begin
          bit_cnt <= bit_cnt + 1'b1;
          done    <= rx_s && bit_cnt == LAST_S;
          if (!rx_s || bit_cnt == LAST_S) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  // a completing frame takes priority over a same-cycle acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data     <= '0;
      data_ready   <= 1'b0;
      overwritten  <= 1'b0;
      parity_error <= 1'b0;
    end else if (done) begin
      out_data     <= sh;
      parity_error <= perr;
      data_ready   <= 1'b1;
      overwritten  <= data_ready & ~data_readed;
    end else if (data_readed) begin
      data_ready  <= 1'b0;
      overwritten <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus against a frame-level reference model
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB = 32;
  localparam real BIT_NS = 320.0;
  logic clk = 0, rst = 1, rx = 1, data_readed = 0;
  logic [7:0] out_data;
  logic data_ready, overwritten, parity_error;
  int total = 0, bad = 0;
  logic [7:0] exp_data = 0;
  logic exp_rdy = 0, exp_ovw = 0, exp_perr = 0;
  always #5 clk = ~clk;
  uart_rx #(
    .CLK_FREQ(3_200_000), .BAUD_RATE(100_000), .DATA_LEN(8), .PARITY_BIT(2), .STOP_BIT(1)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_readed(data_readed),
    .out_data(out_data), .data_ready(data_ready), .overwritten(overwritten),
    .parity_error(parity_error)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  task automatic check_all(input string tag);
    @(negedge clk);
    chk({tag, ".data"}, out_data, exp_data);
    chk({tag, ".ready"}, {7'd0, data_ready}, {7'd0, exp_rdy});
    chk({tag, ".ovw"}, {7'd0, overwritten}, {7'd0, exp_ovw});
    chk({tag, ".perr"}, {7'd0, parity_error}, {7'd0, exp_perr});
  endtask
  task automatic ack();
    @(negedge clk) data_readed = 1;
    @(negedge clk) data_readed = 0;
    exp_rdy = 0;
    exp_ovw = 0;
  endtask
  // even parity frame; par_ok=0 flips the parity bit, stop_ok=0 sends a low stop bit
  task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok,
                            input real scale, input bit ack_stop);
    real bt, t0;
    bit seen0, seen1;
    bt = BIT_NS * scale;
    rx = 0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bt);
    end
    rx = (^d) ^ !par_ok;
    #(bt);
    rx = stop_ok;
    if (ack_stop) begin
      t0 = $realtime;
      @(negedge clk) data_readed = 1;
      seen0 = 0;
      seen1 = 0;
      for (int i = 0; i < 3 * CPB && !seen1; i++) begin
        @(negedge clk);
        if (!data_ready) seen0 = 1;
        else if (seen0) seen1 = 1;
      end
      data_readed = 0;
      chk("ack_in_stop.seen", {7'd0, seen1}, 8'd1);
      if (bt - ($realtime - t0) > 0) #(bt - ($realtime - t0));
    end else #(bt);
    rx = 1;
    #(bt);
    if (stop_ok) begin
      exp_data = d;
      exp_perr = !par_ok;
      exp_ovw  = ack_stop ? 1'b0 : exp_rdy;
      exp_rdy  = 1;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    logic [7:0] d;
    bit par_ok, stop_ok, ack_stop;
    real scale;
    rst = 1;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 0;
    #(BIT_NS);
    send_frame(8'h49, 1, 1, 1.0, 0);
    check_all("t1");
    ack();
    check_all("t2_ack");
    send_frame(8'h49, 0, 1, 1.0, 0);
    check_all("t2");
    ack();
    send_frame(8'h49, 1, 1, 1.0, 0);
    send_frame(8'hA5, 1, 1, 1.0, 0);
    check_all("t3");
    ack();
    check_all("t3_ack");
    rx = 0;
    #30;
    rx = 1;
    #(3 * BIT_NS);
    check_all("t4_glitch");
    send_frame(8'h3C, 1, 1, 1.0, 0);
    check_all("t4");
    send_frame(8'hF0, 1, 0, 1.0, 0);
    check_all("t5_frame");
    send_frame(8'h55, 1, 1, 1.0, 0);
    check_all("t5");
    send_frame(8'h5A, 1, 1, 1.0, 1);
    check_all("ack_race");
    rx = 0;
    #(BIT_NS);
    rx = 1;
    #(BIT_NS);
    rx = 0;
    #(1.5 * BIT_NS + 3);
    rst = 1;
    #1;
    chk("t6_rst.data", out_data, 8'h00);
    chk("t6_rst.ready", {7'd0, data_ready}, 8'd0);
    chk("t6_rst.ovw", {7'd0, overwritten}, 8'd0);
    chk("t6_rst.perr", {7'd0, parity_error}, 8'd0);
    exp_data = 0;
    exp_rdy = 0;
    exp_ovw = 0;
    exp_perr = 0;
    rx = 1;
    #20;
    @(negedge clk) rst = 0;
    #(2 * BIT_NS);
    send_frame(8'h81, 1, 1, 1.0, 0);
    check_all("t6");
    repeat (30) begin
      d = 8'($urandom);
      par_ok = $urandom_range(0, 3) != 0;
      stop_ok = $urandom_range(0, 7) != 0;
      ack_stop = stop_ok && $urandom_range(0, 5) == 0;
      scale = 0.98 + 0.04 * $urandom_range(0, 100) / 100.0;
      if ($urandom_range(0, 1) == 1) ack();
      send_frame(d, par_ok, stop_ok, scale, ack_stop);
      check_all("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
